// File: rtl/id_exe_stage_reg.sv
// ID/EXE pipeline register: captures decoded control and operands each cycle,
// with flush/freeze/bubble handling and saturating bubble/flush event counters.
module id_exe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              freeze,
    input  logic              hazard,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [3:0]        exe_cmd_in,
    input  logic              mem_read_in,
    input  logic              mem_write_in,
    input  logic              wb_en_in,
    input  logic              s_in,
    input  logic              b_in,
    input  logic [DATA_W-1:0] val_rn_in,
    input  logic [DATA_W-1:0] val_rm_in,
    input  logic              imm_in,
    input  logic [11:0]       shift_operand_in,
    input  logic [23:0]       signed_imm_24_in,
    input  logic [3:0]        dest_in,
    input  logic [3:0]        src1_in,
    input  logic [3:0]        src2_in,
    input  logic [3:0]        status_in,
    output logic              valid_out,
    output logic [DATA_W-1:0] pc_out,
    output logic [3:0]        exe_cmd_out,
    output logic              mem_read_out,
    output logic              mem_write_out,
    output logic              wb_en_out,
    output logic              s_out,
    output logic              b_out,
    output logic [DATA_W-1:0] val_rn_out,
    output logic [DATA_W-1:0] val_rm_out,
    output logic              imm_out,
    output logic [11:0]       shift_operand_out,
    output logic [23:0]       signed_imm_24_out,
    output logic [3:0]        dest_out,
    output logic [3:0]        src1_out,
    output logic [3:0]        src2_out,
    output logic [3:0]        status_out,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] pc;
        logic [3:0]        exe_cmd;
        logic              mem_read;
        logic              mem_write;
        logic              wb_en;
        logic              s;
        logic              b;
        logic [DATA_W-1:0] val_rn;
        logic [DATA_W-1:0] val_rm;
        logic              imm;
        logic [11:0]       shift_operand;
        logic [23:0]       signed_imm_24;
        logic [3:0]        dest;
        logic [3:0]        src1;
        logic [3:0]        src2;
        logic [3:0]        status;
    } stage_t;

    stage_t stage_in;
    stage_t stage_reg;
    stage_t stage_next;
    logic [1:0] event_hit;

    assign stage_in = '{
        valid:         valid_in,
        pc:            pc_in,
        exe_cmd:       exe_cmd_in,
        mem_read:      mem_read_in,
        mem_write:     mem_write_in,
        wb_en:         wb_en_in,
        s:             s_in,
        b:             b_in,
        val_rn:        val_rn_in,
        val_rm:        val_rm_in,
        imm:           imm_in,
        shift_operand: shift_operand_in,
        signed_imm_24: signed_imm_24_in,
        dest:          dest_in,
        src1:          src1_in,
        src2:          src2_in,
        status:        status_in
    };

    // An all-zero slot decodes as a no-op downstream, so flush and bubble share it.
    always_comb begin
        stage_next = stage_in;
        if (flush) begin
            stage_next = '0;
        end else if (freeze) begin
            stage_next = stage_reg;
        end else if (hazard) begin
            stage_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_reg <= '0;
        end else begin
            stage_reg <= stage_next;
        end
    end

    // index 0: bubble inserted, index 1: capture flushed
    assign event_hit[0] = !flush && !freeze && hazard;
    assign event_hit[1] = flush;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg;
            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_reg <= '0;
                end else if (event_hit[gi] && !(&cnt_reg)) begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end
        end
    endgenerate

    assign bubble_cnt = g_cnt[0].cnt_reg;
    assign flush_cnt  = g_cnt[1].cnt_reg;

    assign valid_out         = stage_reg.valid;
    assign pc_out            = stage_reg.pc;
    assign exe_cmd_out       = stage_reg.exe_cmd;
    assign mem_read_out      = stage_reg.mem_read;
    assign mem_write_out     = stage_reg.mem_write;
    assign wb_en_out         = stage_reg.wb_en;
    assign s_out             = stage_reg.s;
    assign b_out             = stage_reg.b;
    assign val_rn_out        = stage_reg.val_rn;
    assign val_rm_out        = stage_reg.val_rm;
    assign imm_out           = stage_reg.imm;
    assign shift_operand_out = stage_reg.shift_operand;
    assign signed_imm_24_out = stage_reg.signed_imm_24;
    assign dest_out          = stage_reg.dest;
    assign src1_out          = stage_reg.src1;
    assign src2_out          = stage_reg.src2;
    assign status_out        = stage_reg.status;

endmodule

// File: tb/tb_id_exe_stage_reg.sv
// Directed bench for id_exe_stage_reg: reset, load, freeze, flush, hazard and
// counter saturation (counters built 4 bits wide).
module tb_id_exe_stage_reg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;
    localparam int VW     = 1 + DATA_W + 4 + 5 + 2*DATA_W + 1 + 12 + 24 + 16;

    logic              clk = 1'b0;
    logic              rst, flush, freeze, hazard;
    logic              valid_in;
    logic [DATA_W-1:0] pc_in;
    logic [3:0]        exe_cmd_in;
    logic              mem_read_in, mem_write_in, wb_en_in, s_in, b_in;
    logic [DATA_W-1:0] val_rn_in, val_rm_in;
    logic              imm_in;
    logic [11:0]       shift_operand_in;
    logic [23:0]       signed_imm_24_in;
    logic [3:0]        dest_in, src1_in, src2_in, status_in;

    logic              valid_out;
    logic [DATA_W-1:0] pc_out;
    logic [3:0]        exe_cmd_out;
    logic              mem_read_out, mem_write_out, wb_en_out, s_out, b_out;
    logic [DATA_W-1:0] val_rn_out, val_rm_out;
    logic              imm_out;
    logic [11:0]       shift_operand_out;
    logic [23:0]       signed_imm_24_out;
    logic [3:0]        dest_out, src1_out, src2_out, status_out;
    logic [CNT_W-1:0]  bubble_cnt, flush_cnt;

    logic [VW-1:0] in_vec, out_vec, exp_a, exp_b;
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    id_exe_stage_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .flush(flush), .freeze(freeze), .hazard(hazard),
        .valid_in(valid_in), .pc_in(pc_in), .exe_cmd_in(exe_cmd_in),
        .mem_read_in(mem_read_in), .mem_write_in(mem_write_in), .wb_en_in(wb_en_in),
        .s_in(s_in), .b_in(b_in), .val_rn_in(val_rn_in), .val_rm_in(val_rm_in),
        .imm_in(imm_in), .shift_operand_in(shift_operand_in),
        .signed_imm_24_in(signed_imm_24_in), .dest_in(dest_in), .src1_in(src1_in),
        .src2_in(src2_in), .status_in(status_in),
        .valid_out(valid_out), .pc_out(pc_out), .exe_cmd_out(exe_cmd_out),
        .mem_read_out(mem_read_out), .mem_write_out(mem_write_out), .wb_en_out(wb_en_out),
        .s_out(s_out), .b_out(b_out), .val_rn_out(val_rn_out), .val_rm_out(val_rm_out),
        .imm_out(imm_out), .shift_operand_out(shift_operand_out),
        .signed_imm_24_out(signed_imm_24_out), .dest_out(dest_out), .src1_out(src1_out),
        .src2_out(src2_out), .status_out(status_out),
        .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
    );

    assign in_vec  = {valid_in, pc_in, exe_cmd_in, mem_read_in, mem_write_in, wb_en_in,
                      s_in, b_in, val_rn_in, val_rm_in, imm_in, shift_operand_in,
                      signed_imm_24_in, dest_in, src1_in, src2_in, status_in};
    assign out_vec = {valid_out, pc_out, exe_cmd_out, mem_read_out, mem_write_out, wb_en_out,
                      s_out, b_out, val_rn_out, val_rm_out, imm_out, shift_operand_out,
                      signed_imm_24_out, dest_out, src1_out, src2_out, status_out};

    task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        total++;
        assert (obs === exp)
            $display("check %s ok: %0h", tag, obs);
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a();
        valid_in = 1'b1; pc_in = 32'h0000_0010; exe_cmd_in = 4'b0010;
        mem_read_in = 1'b0; mem_write_in = 1'b0; wb_en_in = 1'b1; s_in = 1'b0; b_in = 1'b0;
        val_rn_in = 32'hDEAD_BEEF; val_rm_in = 32'h0000_0005; imm_in = 1'b0;
        shift_operand_in = 12'h005; signed_imm_24_in = 24'h0; dest_in = 4'd3;
        src1_in = 4'd1; src2_in = 4'd5; status_in = 4'b0000;
    endtask

    task automatic set_b();
        valid_in = 1'b1; pc_in = 32'h0000_0014; exe_cmd_in = 4'b0100;
        mem_read_in = 1'b1; mem_write_in = 1'b0; wb_en_in = 1'b1; s_in = 1'b1; b_in = 1'b0;
        val_rn_in = 32'h1234_5678; val_rm_in = 32'hCAFE_F00D; imm_in = 1'b1;
        shift_operand_in = 12'hABC; signed_imm_24_in = 24'h00_0123; dest_in = 4'd7;
        src1_in = 4'd2; src2_in = 4'd9; status_in = 4'b1010;
    endtask

    task automatic set_all_ones();
        valid_in = 1'b1; pc_in = '1; exe_cmd_in = '1; mem_read_in = 1'b1; mem_write_in = 1'b1;
        wb_en_in = 1'b1; s_in = 1'b1; b_in = 1'b1; val_rn_in = '1; val_rm_in = '1; imm_in = 1'b1;
        shift_operand_in = '1; signed_imm_24_in = '1; dest_in = '1; src1_in = '1;
        src2_in = '1; status_in = '1;
    endtask

    initial begin
        flush = 1'b0; freeze = 1'b1; hazard = 1'b1;
        // reset with every data/control input nonzero
        rst = 1'b1;
        set_all_ones();
        step();
        chk("reset_out", out_vec, '0);
        chk("reset_bubble", VW'(bubble_cnt), VW'(0));
        chk("reset_flush", VW'(flush_cnt), VW'(0));

        // normal load of A, with hand-written expected image
        rst = 1'b0; freeze = 1'b0; hazard = 1'b0;
        set_a();
        exp_a = {1'b1, 32'h0000_0010, 4'b0010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                 32'hDEAD_BEEF, 32'h0000_0005, 1'b0, 12'h005, 24'h0, 4'd3, 4'd1, 4'd5, 4'd0};
        step();
        chk("load_a", out_vec, exp_a);
        chk("load_a_pc", VW'(pc_out), VW'(32'h10));
        chk("load_a_bubble", VW'(bubble_cnt), VW'(0));
        chk("load_a_flush", VW'(flush_cnt), VW'(0));

        // freeze for 3 cycles while inputs move to B
        freeze = 1'b1;
        set_b();
        exp_b = {1'b1, 32'h0000_0014, 4'b0100, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0,
                 32'h1234_5678, 32'hCAFE_F00D, 1'b1, 12'hABC, 24'h00_0123, 4'd7, 4'd2, 4'd9, 4'b1010};
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("freeze_hold_%0d", i), out_vec, exp_a);
        end
        freeze = 1'b0;
        step();
        chk("unfreeze_b", out_vec, exp_b);

        // invalid capture is loaded as-is and not counted
        valid_in = 1'b0;
        step();
        chk("invalid_load", out_vec, {1'b0, exp_b[VW-2:0]});
        chk("invalid_bubble", VW'(bubble_cnt), VW'(0));

        // flush beats freeze
        set_a();
        step();
        chk("reload_a", out_vec, exp_a);
        freeze = 1'b1; flush = 1'b1; set_b();
        step();
        chk("flush_freeze_out", out_vec, '0);
        chk("flush_cnt_1", VW'(flush_cnt), VW'(1));
        chk("flush_bubble_0", VW'(bubble_cnt), VW'(0));

        // hazard inserts a bubble
        freeze = 1'b0; flush = 1'b0;
        set_a();
        step();
        chk("load_a_again", out_vec, exp_a);
        hazard = 1'b1; mem_read_in = 1'b1;
        step();
        chk("hazard_out", out_vec, '0);
        chk("hazard_bubble_1", VW'(bubble_cnt), VW'(1));
        chk("hazard_flush_1", VW'(flush_cnt), VW'(1));

        // hazard while frozen is ignored
        hazard = 1'b0;
        set_a();
        step();
        chk("load_a_3", out_vec, exp_a);
        hazard = 1'b1; freeze = 1'b1; set_b();
        step();
        chk("hazard_freeze_hold", out_vec, exp_a);
        chk("hazard_freeze_bubble", VW'(bubble_cnt), VW'(1));

        // 17 hazard cycles: count climbs from 1 and sticks at 15
        freeze = 1'b0;
        for (int i = 1; i <= 17; i++) begin
            step();
            chk($sformatf("sat_bubble_%0d", i), VW'(bubble_cnt), VW'((1 + i > 15) ? 15 : 1 + i));
        end
        chk("sat_out", out_vec, '0);

        // reset while frozen with hazard asserted
        rst = 1'b1; freeze = 1'b1;
        set_all_ones();
        step();
        chk("rst_mid_out", out_vec, '0);
        chk("rst_mid_bubble", VW'(bubble_cnt), VW'(0));
        chk("rst_mid_flush", VW'(flush_cnt), VW'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
